// File: rtl/smpl_mem_arbiter_if.sv
// smpl_mem_arbiter_if
//   Bundles the three buses around the shared program/data SRAM:
//     fetch port : i_req, i_addr -> i_gnt, i_rvalid, i_rdata
//     data port  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//     memory     : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
//   slave  : the arbiter's view.
//   master : the surrounding system's view (core ports plus the SRAM).
interface smpl_mem_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 16
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/smpl_mem_arbiter.sv
// smpl_mem_arbiter
//   Shares one single-port synchronous SRAM between the smpl_core fetch
//   port and data port. One access per cycle; data wins ties unless fetch
//   has been denied STARVE_MAX consecutive cycles. Read data is steered back
//   to its owner RD_LAT cycles after the grant by a {valid, owner} tag pipe.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : smpl_mem_arbiter_if.slave (fetch, data and memory buses)
module smpl_mem_arbiter #(
  parameter int AW         = 13,
  parameter int DW         = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  smpl_mem_arbiter_if.slave     bus
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0]     starve_q, starve_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_own_q;  // owner: 1 = data, 0 = fetch
  logic              tag_vld_d, tag_own_d;
  logic              d_win, i_win;
  logic [AW-1:0]     addr_mux;
  logic [DW-1:0]     wdata_mux;
  logic              rd_i, rd_d;

  // Grant decision, combinational in the request cycle. Grants are held
  // low for the whole of reset even if requests are present.
  always_comb begin
    d_win = 1'b0;
    i_win = 1'b0;
    if (!reset) begin
      if (bus.d_req && (!bus.i_req || (starve_q < STARVE_LIM))) begin
        d_win = 1'b1;
      end else if (bus.i_req) begin
        i_win = 1'b1;
      end
    end
  end

  // Fetch is always a read, so only a data winner can drive write data.
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    if (d_win) begin
      addr_mux  = bus.d_addr;
      wdata_mux = bus.d_wdata;
    end else if (i_win) begin
      addr_mux  = bus.i_addr;
    end
  end

  assign bus.i_gnt     = i_win;
  assign bus.d_gnt     = d_win;
  assign bus.mem_en    = i_win | d_win;
  assign bus.mem_we    = d_win & bus.d_we;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;

  // Starvation counter: counts consecutive denied fetch cycles, saturating.
  always_comb begin
    starve_d = '0;
    if (bus.i_req && !i_win) begin
      starve_d = (starve_q >= STARVE_LIM) ? starve_q : starve_q + 1'b1;
    end
  end

  // Only reads enter the tag pipe; writes never return data.
  assign tag_vld_d = (i_win | d_win) & !(d_win & bus.d_we);
  assign tag_own_d = d_win;

  // Request stage -> tag pipe stage 0 .. RD_LAT-1 (exit lines up with mem_rdata)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q  <= '0;
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      starve_q     <= starve_d;
      tag_vld_q[0] <= tag_vld_d;
      tag_own_q[0] <= tag_own_d;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_own_q[k] <= tag_own_q[k-1];
      end
    end
  end

  // Tag exit: route memory data to its owner, zero otherwise.
  assign rd_i = tag_vld_q[RD_LAT-1] & !tag_own_q[RD_LAT-1];
  assign rd_d = tag_vld_q[RD_LAT-1] &  tag_own_q[RD_LAT-1];

  assign bus.i_rvalid = rd_i;
  assign bus.d_rvalid = rd_d;
  assign bus.i_rdata  = rd_i ? bus.mem_rdata : '0;
  assign bus.d_rdata  = rd_d ? bus.mem_rdata : '0;

endmodule

// File: doc/smpl_mem_arbiter.md
Name: smpl_mem_arbiter

Overview:
- Shares one single-port synchronous SRAM between the smpl_core instruction-fetch port and its data port.
- Grants at most one access per cycle. Data has priority over fetch, with a starvation guard that stops fetch being locked out.
- Returns read data to the owning requester after a fixed memory latency, using a tag pipeline.
- Sits between smpl_core (iaddr/idata, daddr/datai/datao/renbl/wenbl) and the unified program/data memory.

Parameters:
- AW, 13, address width (matches core iaddr/daddr).
- DW, 16, data width (matches core idata/datai/datao).
- RD_LAT, 1, memory read latency in cycles, legal range 1..4.
- STARVE_MAX, 3, consecutive denied fetch cycles before fetch is forced to win.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held with i_addr until i_gnt.
- i_addr  in  AW  fetch address.
- i_gnt  out  1  fetch granted this cycle.
- i_rvalid  out  1  fetch read data valid.
- i_rdata  out  DW  fetch read data.
- d_req  in  1  data request (core renbl | wenbl).
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_gnt  out  1  data granted this cycle.
- d_rvalid  out  1  data read data valid (reads only).
- d_rdata  out  DW  data read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after the mem_en cycle.

Behaviour:
- Reset (async assert, sync release):
  - tag pipeline cleared; starve_cnt = 0.
  - i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en and mem_we all 0.
  - rdata outputs are 0.
  - While reset is high, grants are forced to 0 regardless of the req inputs.
- Arbitration is combinational in the request cycle. Priority decision:
  - d_req only -> data wins.
  - i_req only -> fetch wins.
  - both, and starve_cnt < STARVE_MAX -> data wins.
  - both, and starve_cnt == STARVE_MAX -> fetch wins.
- Winner side effects:
  - The winner's gnt = 1.
  - mem_en = 1.
  - mem_addr, mem_we and mem_wdata are muxed from the winner.
  - Fetch is always a read, so mem_we = 0 and mem_wdata = 0.
- No request: mem_en = 0, mem_we = 0, mem_addr and mem_wdata hold 0.
- Requester obligations:
  - req and the associated addr/we/wdata must stay stable until the cycle gnt = 1.
  - req is removed (or a new request presented) on the cycle after the grant.
  - The arbiter does not check this.
- Starvation counter, updated each edge:
  - i_req & !i_gnt -> starve_cnt++ (saturating at STARVE_MAX).
  - i_gnt or !i_req -> starve_cnt = 0.
- Tag pipeline:
  - RD_LAT-stage shift register of {valid, owner}.
  - Stage 0 loads {mem_en & !mem_we, owner} each cycle.
  - On exit from the last stage, the matching rvalid is asserted for exactly 1 cycle.
  - Exit timing: the rvalid cycle is RD_LAT cycles after the grant cycle, the same cycle mem_rdata is valid.
  - mem_rdata is routed combinationally to the owner's rdata while its rvalid = 1. The owner's rdata is 0 otherwise.
  - Writes never produce rvalid.
- Back-to-back grants every cycle are supported. i_rvalid and d_rvalid are never both 1 in the same cycle.
- Reset mid-operation: all in-flight tags are discarded, so no rvalid follows reset deassertion for pre-reset grants. starve_cnt restarts at 0.
- Address/data pass through unmodified. No width conversion and no wrap logic; the address space is 2^AW words.

Test Plan:
- Reset with i_req = d_req = 1: all outputs 0 throughout reset. After release, d_gnt = 1 and i_gnt = 0 in the first cycle.
- Fetch only, i_addr = 0x0005, mem_rdata = 0x2001 on return: i_gnt = 1 in cycle T; i_rvalid = 1 with i_rdata = 0x2001 at T+RD_LAT (T+1 by default); d_rvalid stays 0.
- Data write, d_we = 1, d_addr = 0x0AB, d_wdata = 0x1757: mem_en = mem_we = 1 with matching addr/wdata in the grant cycle; no d_rvalid ever follows.
- Continuous d_req reads plus held i_req, STARVE_MAX = 3: d_gnt for 3 cycles, then i_gnt on the 4th cycle, then d_gnt resumes. Each d_rvalid/i_rvalid lands RD_LAT after its own grant.
- RD_LAT = 3, alternating fetch/data reads for 6 cycles: rvalids return in grant order, with the correct owner and the matching mem_rdata value each cycle.
- Assert reset one cycle after a data read grant with RD_LAT = 2, release next cycle: no d_rvalid is ever produced for that read, and starve_cnt = 0.
